// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side frame deframer.
package uart_pkg;

    typedef enum logic [1:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CHK
    } deframe_state_t;

    typedef logic [2:0] frame_status_t;

    localparam frame_status_t ST_OK  = 3'd0;
    localparam frame_status_t ST_CHK = 3'd1;
    localparam frame_status_t ST_LEN = 3'd2;
    localparam frame_status_t ST_PAR = 3'd3;
    localparam frame_status_t ST_TMO = 3'd4;

    localparam logic [7:0] DEFAULT_SOF = 8'h7E;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at its maximum instead of wrapping.
module sat_counter16
    import uart_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    output logic [15:0] count_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = sat_inc16(count_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/uart_rx_deframer.sv
// Pulls bytes from the UART rx FIFO, parses SOF/LEN/payload/CHK frames,
// streams the payload out and reports a status pulse plus good/bad totals.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter logic [7:0]  SOF_BYTE       = DEFAULT_SOF,
    parameter int unsigned MAX_LEN        = 64,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RXF_NOT_EMPTY,
    input  logic [7:0]  RXF_DATA,
    input  logic        RXF_PARITY_ERR,
    output logic        RXF_POP,
    output logic [7:0]  OUT_DATA,
    output logic        OUT_VALID,
    output logic        OUT_LAST,
    input  logic        OUT_READY,
    output logic        FRAME_DONE,
    output logic [2:0]  FRAME_STATUS,
    output logic [15:0] GOOD_CNT,
    output logic [15:0] BAD_CNT
);

    localparam int unsigned      TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

    deframe_state_t   state_q, state_d;
    logic             gap_q;
    logic [7:0]       remaining_q, remaining_d;
    logic [7:0]       chk_q, chk_d;
    logic             perr_q, perr_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             done_q, done_d;
    frame_status_t    status_q, status_d;

    logic out_accept;
    logic out_hold;
    logic can_take;
    logic pop;

    always_comb begin
        out_accept = out_valid_q & OUT_READY;
        out_hold   = out_valid_q & ~OUT_READY;
        // Payload bytes need a free (or freeing) output slot; other states always consume.
        can_take   = (state_q != PAYLOAD) | ~out_valid_q | OUT_READY;
        pop        = RXF_NOT_EMPTY & ~gap_q & can_take & ~RST;
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        chk_d       = chk_q;
        perr_d      = perr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        status_d    = status_q;

        if (out_accept) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if ((state_q == HUNT) || pop) begin
            tmo_d = '0;
        end else if (out_hold) begin
            tmo_d = tmo_q;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        case (state_q)
            HUNT: begin
                if (pop && (RXF_DATA == SOF_BYTE) && !RXF_PARITY_ERR) begin
                    state_d = LEN;
                    perr_d  = 1'b0;
                end
            end
            LEN: begin
                if (pop) begin
                    remaining_d = RXF_DATA;
                    chk_d       = RXF_DATA;
                    if (RXF_PARITY_ERR) begin
                        done_d   = 1'b1;
                        status_d = ST_PAR;
                        state_d  = HUNT;
                    end else if (RXF_DATA > MAX_LEN_B) begin
                        done_d   = 1'b1;
                        status_d = ST_LEN;
                        state_d  = HUNT;
                    end else if (RXF_DATA == 8'd0) begin
                        state_d = CHK;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (pop) begin
                    out_data_d  = RXF_DATA;
                    out_valid_d = 1'b1;
                    out_last_d  = (remaining_q == 8'd1);
                    chk_d       = chk_q ^ RXF_DATA;
                    remaining_d = remaining_q - 8'd1;
                    perr_d      = perr_q | RXF_PARITY_ERR;
                    if (remaining_q == 8'd1) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (pop) begin
                    done_d  = 1'b1;
                    state_d = HUNT;
                    if (perr_q || RXF_PARITY_ERR) begin
                        status_d = ST_PAR;
                    end else if (RXF_DATA != chk_q) begin
                        status_d = ST_CHK;
                    end else begin
                        status_d = ST_OK;
                    end
                end
            end
        endcase

        // A pop in the same cycle always beats the timeout.
        if ((state_q != HUNT) && !pop && !out_hold && (tmo_q == TMO_LAST)) begin
            done_d   = 1'b1;
            status_d = ST_TMO;
            state_d  = HUNT;
            tmo_d    = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= HUNT;
            gap_q       <= 1'b0;
            perr_q      <= 1'b0;
            tmo_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            status_q    <= ST_OK;
        end else begin
            state_q     <= state_d;
            gap_q       <= pop;
            perr_q      <= perr_d;
            tmo_q       <= tmo_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            status_q    <= status_d;
        end
    end

    always_ff @(posedge CLK) begin
        remaining_q <= remaining_d;
        chk_q       <= chk_d;
    end

    // Counters advance on the same edge that raises FRAME_DONE.
    sat_counter16 u_good_cnt (
        .clk_i   (CLK),
        .rst_i   (RST),
        .inc_i   (done_d & (status_d == ST_OK)),
        .count_o (GOOD_CNT)
    );

    sat_counter16 u_bad_cnt (
        .clk_i   (CLK),
        .rst_i   (RST),
        .inc_i   (done_d & (status_d != ST_OK)),
        .count_o (BAD_CNT)
    );

    assign RXF_POP      = pop;
    assign OUT_DATA     = out_data_q;
    assign OUT_VALID    = out_valid_q;
    assign OUT_LAST     = out_last_q;
    assign FRAME_DONE   = done_q;
    assign FRAME_STATUS = status_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: FIFO model feeding the DUT, a frame-level parser as reference.
module tb_uart_rx_deframer;

    localparam int TMO  = 50;
    localparam int MAXL = 64;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RXF_NOT_EMPTY = 1'b0;
    logic [7:0]  RXF_DATA = 8'h00;
    logic        RXF_PARITY_ERR = 1'b0;
    logic        RXF_POP;
    logic [7:0]  OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_LAST;
    logic        OUT_READY = 1'b1;
    logic        FRAME_DONE;
    logic [2:0]  FRAME_STATUS;
    logic [15:0] GOOD_CNT;
    logic [15:0] BAD_CNT;

    uart_rx_deframer #(
        .SOF_BYTE       (8'h7E),
        .MAX_LEN        (MAXL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .RXF_NOT_EMPTY  (RXF_NOT_EMPTY),
        .RXF_DATA       (RXF_DATA),
        .RXF_PARITY_ERR (RXF_PARITY_ERR),
        .RXF_POP        (RXF_POP),
        .OUT_DATA       (OUT_DATA),
        .OUT_VALID      (OUT_VALID),
        .OUT_LAST       (OUT_LAST),
        .OUT_READY      (OUT_READY),
        .FRAME_DONE     (FRAME_DONE),
        .FRAME_STATUS   (FRAME_STATUS),
        .GOOD_CNT       (GOOD_CNT),
        .BAD_CNT        (BAD_CNT)
    );

    always #5 CLK = ~CLK;

    // entries are {parity_err, byte}; beats are {last, data}
    bit [8:0] fifo[$];
    bit [8:0] stim[$];
    bit [8:0] beats[$];
    bit [8:0] exp_beats[$];
    bit [2:0] dones[$];
    bit [2:0] exp_stat[$];

    int cyc = 0;
    int pops = 0;
    int pop_cyc = 0;
    int done_cyc = 0;
    int gap_viol = 0;
    bit prev_pop = 1'b0;
    bit valid_seen = 1'b0;
    int ready_mode = 0;
    int total = 0;
    int bad = 0;
    int exp_good = 0;
    int exp_bad = 0;

    // FIFO and sink model: updates inputs 1ns after each rising edge.
    initial begin
        bit popped;
        forever begin
            @(posedge CLK);
            popped = RXF_POP;
            cyc++;
            #1;
            if (popped && fifo.size() > 0) void'(fifo.pop_front());
            RXF_NOT_EMPTY = (fifo.size() > 0);
            if (fifo.size() > 0) begin
                RXF_DATA       = fifo[0][7:0];
                RXF_PARITY_ERR = fifo[0][8];
            end
            case (ready_mode)
                0:       OUT_READY = 1'b1;
                1:       OUT_READY = ($urandom_range(0, 3) != 0);
                default: OUT_READY = 1'b0;
            endcase
        end
    end

    // Observation on the falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            if (OUT_VALID) valid_seen = 1'b1;
            if (OUT_VALID && OUT_READY) beats.push_back({OUT_LAST, OUT_DATA});
            if (FRAME_DONE) begin
                dones.push_back(FRAME_STATUS);
                done_cyc = cyc;
            end
            if (RXF_POP) begin
                pops++;
                pop_cyc = cyc;
                if (prev_pop) gap_viol++;
            end
            prev_pop = RXF_POP;
        end
    end

    task automatic note_status(input bit [2:0] s);
        exp_stat.push_back(s);
        if (s == 3'd0) begin
            if (exp_good < 65535) exp_good++;
        end else begin
            if (exp_bad < 65535) exp_bad++;
        end
    endtask

    // Reference: walk the byte stream frame by frame.
    task automatic model_run();
        int i = 0;
        int n = stim.size();
        while (i < n) begin
            int len;
            bit perr;
            bit [7:0] x;
            if (stim[i][7:0] != 8'h7E || stim[i][8]) begin
                i++;
                continue;
            end
            if (i + 1 >= n) begin
                note_status(3'd4);
                return;
            end
            len = int'(stim[i+1][7:0]);
            if (stim[i+1][8]) begin
                note_status(3'd3);
                i += 2;
                continue;
            end
            if (len > MAXL) begin
                note_status(3'd2);
                i += 2;
                continue;
            end
            perr = 1'b0;
            x = stim[i+1][7:0];
            for (int j = 0; j < len; j++) begin
                if (i + 2 + j >= n) begin
                    note_status(3'd4);
                    return;
                end
                exp_beats.push_back({(j == len - 1), stim[i+2+j][7:0]});
                x = x ^ stim[i+2+j][7:0];
                perr = perr | stim[i+2+j][8];
            end
            if (i + 2 + len >= n) begin
                note_status(3'd4);
                return;
            end
            if (perr || stim[i+2+len][8])       note_status(3'd3);
            else if (stim[i+2+len][7:0] != x)   note_status(3'd1);
            else                                note_status(3'd0);
            i += len + 3;
        end
    endtask

    task automatic clear_obs();
        beats.delete();
        dones.delete();
        exp_beats.delete();
        exp_stat.delete();
        valid_seen = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        int quiet = 0;
        ok = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge CLK);
            if (fifo.size() == 0 && !OUT_VALID && !RXF_POP) quiet++;
            else quiet = 0;
            if (quiet >= 4) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic run_stim(output bit ok);
        model_run();
        foreach (stim[k]) fifo.push_back(stim[k]);
        stim.delete();
        wait_idle(ok);
    endtask

    function automatic int beat_diffs();
        int d = (beats.size() != exp_beats.size()) ? 1 : 0;
        for (int k = 0; k < beats.size() && k < exp_beats.size(); k++)
            if (beats[k] !== exp_beats[k]) d++;
        return d;
    endfunction

    function automatic int stat_diffs();
        int d = (dones.size() != exp_stat.size()) ? 1 : 0;
        for (int k = 0; k < dones.size() && k < exp_stat.size(); k++)
            if (dones[k] !== exp_stat[k]) d++;
        return d;
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        total++;
        if ({OUT_VALID, OUT_LAST, FRAME_DONE, RXF_POP} !== 4'b0) begin
            $display("FAIL reset_ctrl: got %b want 0000", {OUT_VALID, OUT_LAST, FRAME_DONE, RXF_POP});
            bad++;
        end
        total++;
        if ({OUT_DATA, FRAME_STATUS} !== 11'h0) begin
            $display("FAIL reset_data: got %h want 0", {OUT_DATA, FRAME_STATUS});
            bad++;
        end
        total++;
        if ({GOOD_CNT, BAD_CNT} !== 32'h0) begin
            $display("FAIL reset_cnt: got %h want 0", {GOOD_CNT, BAD_CNT});
            bad++;
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_good_frame();
        bit ok;
        clear_obs();
        ready_mode = 0;
        stim = '{9'h07E, 9'h003, 9'h011, 9'h022, 9'h033, 9'h003};
        run_stim(ok);
        total++;
        if (ok !== 1'b1) begin $display("FAIL good_idle: got %0d want 1", ok); bad++; end
        total++;
        if (beat_diffs() !== 0) begin $display("FAIL good_beats: got %0d diffs want 0", beat_diffs()); bad++; end
        total++;
        if (stat_diffs() !== 0) begin $display("FAIL good_status: got %0d diffs want 0", stat_diffs()); bad++; end
        total++;
        if (GOOD_CNT !== 16'(exp_good)) begin $display("FAIL good_cnt: got %0d want %0d", GOOD_CNT, exp_good); bad++; end
    endtask

    task automatic test_bad_chk();
        bit ok;
        clear_obs();
        stim = '{9'h07E, 9'h003, 9'h011, 9'h022, 9'h033, 9'h0FF};
        run_stim(ok);
        total++;
        if (beat_diffs() !== 0) begin $display("FAIL chk_beats: got %0d diffs want 0", beat_diffs()); bad++; end
        total++;
        if (stat_diffs() !== 0) begin $display("FAIL chk_status: got %0d diffs want 0", stat_diffs()); bad++; end
        total++;
        if (BAD_CNT !== 16'(exp_bad)) begin $display("FAIL chk_badcnt: got %0d want %0d", BAD_CNT, exp_bad); bad++; end
    endtask

    task automatic test_garbage_empty();
        bit ok;
        clear_obs();
        stim = '{9'h055, 9'h0AA, 9'h07E, 9'h000, 9'h000};
        run_stim(ok);
        total++;
        if (stat_diffs() !== 0) begin $display("FAIL empty_status: got %0d diffs want 0", stat_diffs()); bad++; end
        total++;
        if (valid_seen !== 1'b0) begin $display("FAIL empty_valid: got %0d want 0", valid_seen); bad++; end
        total++;
        if (GOOD_CNT !== 16'(exp_good)) begin $display("FAIL empty_cnt: got %0d want %0d", GOOD_CNT, exp_good); bad++; end
    endtask

    task automatic test_bad_len();
        bit ok;
        clear_obs();
        stim = '{9'h07E, 9'h041, 9'h07E, 9'h001, 9'h05A, 9'h05B};
        run_stim(ok);
        total++;
        if (stat_diffs() !== 0) begin $display("FAIL len_status: got %0d diffs want 0", stat_diffs()); bad++; end
        total++;
        if (beat_diffs() !== 0) begin $display("FAIL len_beats: got %0d diffs want 0", beat_diffs()); bad++; end
        total++;
        if ({GOOD_CNT, BAD_CNT} !== {16'(exp_good), 16'(exp_bad)}) begin
            $display("FAIL len_cnts: got %0d/%0d want %0d/%0d", GOOD_CNT, BAD_CNT, exp_good, exp_bad);
            bad++;
        end
    endtask

    task automatic test_stall_timeout();
        bit ok;
        bit got;
        int unstable;
        int p0;
        bit [7:0] d0;
        clear_obs();
        ready_mode = 2;
        stim = '{9'h07E, 9'h003, 9'h011, 9'h022, 9'h033, 9'h003};
        model_run();
        foreach (stim[k]) fifo.push_back(stim[k]);
        stim.delete();
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge CLK);
            got = OUT_VALID;
        end
        total++;
        if (got !== 1'b1) begin $display("FAIL stall_valid: got %0d want 1", got); bad++; end
        d0 = OUT_DATA;
        p0 = pops;
        unstable = 0;
        repeat (1000) begin
            @(negedge CLK);
            if (OUT_DATA !== d0 || OUT_VALID !== 1'b1) unstable++;
        end
        total++;
        if (d0 !== exp_beats[0][7:0]) begin $display("FAIL stall_data: got %h want %h", d0, exp_beats[0][7:0]); bad++; end
        total++;
        if (unstable !== 0) begin $display("FAIL stall_stable: got %0d changes want 0", unstable); bad++; end
        total++;
        if (pops !== p0) begin $display("FAIL stall_pops: got %0d want %0d", pops, p0); bad++; end
        total++;
        if (dones.size() !== 0) begin $display("FAIL stall_done: got %0d want 0", dones.size()); bad++; end
        ready_mode = 0;
        wait_idle(ok);
        total++;
        if (stat_diffs() !== 0 || beat_diffs() !== 0) begin
            $display("FAIL stall_frame: got %0d diffs want 0", stat_diffs() + beat_diffs());
            bad++;
        end

        clear_obs();
        stim = '{9'h07E, 9'h002, 9'h001};
        model_run();
        foreach (stim[k]) fifo.push_back(stim[k]);
        stim.delete();
        got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge CLK);
            got = (dones.size() > 0);
        end
        total++;
        if (got !== 1'b1) begin $display("FAIL tmo_seen: got %0d want 1", got); bad++; end
        total++;
        if (stat_diffs() !== 0) begin $display("FAIL tmo_status: got %0d diffs want 0", stat_diffs()); bad++; end
        total++;
        if (done_cyc - (pop_cyc + 1) !== TMO) begin
            $display("FAIL tmo_delay: got %0d want %0d", done_cyc - (pop_cyc + 1), TMO);
            bad++;
        end
        wait_idle(ok);
        total++;
        if (beat_diffs() !== 0) begin $display("FAIL tmo_beats: got %0d diffs want 0", beat_diffs()); bad++; end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_obs();
        ready_mode = 0;
        fifo.push_back(9'h07E);
        fifo.push_back(9'h005);
        fifo.push_back(9'h0A1);
        fifo.push_back(9'h0A2);
        wait_idle(ok);
        total++;
        if (ok !== 1'b1) begin $display("FAIL rstmid_idle: got %0d want 1", ok); bad++; end
        RST = 1'b1;
        @(negedge CLK);
        total++;
        if ({OUT_VALID, OUT_LAST, FRAME_DONE, RXF_POP, OUT_DATA, FRAME_STATUS} !== 15'h0) begin
            $display("FAIL rstmid_outs: got %h want 0", {OUT_VALID, OUT_LAST, FRAME_DONE, RXF_POP, OUT_DATA, FRAME_STATUS});
            bad++;
        end
        total++;
        if ({GOOD_CNT, BAD_CNT} !== 32'h0) begin $display("FAIL rstmid_cnt: got %h want 0", {GOOD_CNT, BAD_CNT}); bad++; end
        RST = 1'b0;
        @(negedge CLK);
        total++;
        if (dones.size() !== 0) begin $display("FAIL rstmid_done: got %0d want 0", dones.size()); bad++; end
        exp_good = 0;
        exp_bad = 0;
        clear_obs();
        stim = '{9'h07E, 9'h002, 9'h0AB, 9'h0CD, 9'h064};
        run_stim(ok);
        total++;
        if (stat_diffs() !== 0 || beat_diffs() !== 0) begin
            $display("FAIL rstmid_frame: got %0d diffs want 0", stat_diffs() + beat_diffs());
            bad++;
        end
        total++;
        if (GOOD_CNT !== 16'(exp_good)) begin $display("FAIL rstmid_good: got %0d want %0d", GOOD_CNT, exp_good); bad++; end
        clear_obs();
        stim = '{9'h07E, 9'h003, 9'h010, 9'h120, 9'h030, 9'h003};
        run_stim(ok);
        total++;
        if (stat_diffs() !== 0) begin $display("FAIL parity_status: got %0d diffs want 0", stat_diffs()); bad++; end
        total++;
        if (beat_diffs() !== 0) begin $display("FAIL parity_beats: got %0d diffs want 0", beat_diffs()); bad++; end
        total++;
        if (BAD_CNT !== 16'(exp_bad)) begin $display("FAIL parity_badcnt: got %0d want %0d", BAD_CNT, exp_bad); bad++; end
    endtask

    task automatic test_random();
        bit ok;
        clear_obs();
        gap_viol = 0;
        ready_mode = 1;
        for (int f = 0; f < 40; f++) begin
            int kind = $urandom_range(0, 5);
            int len;
            int pidx;
            bit [7:0] x;
            bit [7:0] b;
            case (kind)
                0: begin
                    if ($urandom_range(0, 2) == 0) stim.push_back(9'h17E);
                    repeat ($urandom_range(1, 3)) begin
                        b = 8'($urandom_range(0, 255));
                        if (b == 8'h7E) b = 8'h7D;
                        stim.push_back({($urandom_range(0, 3) == 0), b});
                    end
                end
                3: begin
                    stim.push_back(9'h07E);
                    stim.push_back({1'b0, 8'($urandom_range(MAXL + 1, 255))});
                end
                4: begin
                    stim.push_back(9'h07E);
                    stim.push_back({1'b1, 8'($urandom_range(0, 255))});
                end
                default: begin
                    len = (kind == 5) ? $urandom_range(1, 6) : $urandom_range(0, 8);
                    pidx = (kind == 5) ? $urandom_range(0, len) : -1;
                    x = 8'(len);
                    stim.push_back(9'h07E);
                    stim.push_back({1'b0, 8'(len)});
                    for (int j = 0; j < len; j++) begin
                        b = 8'($urandom_range(0, 255));
                        x = x ^ b;
                        stim.push_back({(j == pidx), b});
                    end
                    if (kind == 2) x = x ^ 8'($urandom_range(1, 255));
                    stim.push_back({(pidx == len), x});
                end
            endcase
        end
        run_stim(ok);
        total++;
        if (ok !== 1'b1) begin $display("FAIL rand_idle: got %0d want 1", ok); bad++; end
        total++;
        if (beat_diffs() !== 0) begin $display("FAIL rand_beats: got %0d diffs want 0", beat_diffs()); bad++; end
        total++;
        if (stat_diffs() !== 0) begin $display("FAIL rand_status: got %0d diffs want 0", stat_diffs()); bad++; end
        total++;
        if ({GOOD_CNT, BAD_CNT} !== {16'(exp_good), 16'(exp_bad)}) begin
            $display("FAIL rand_cnts: got %0d/%0d want %0d/%0d", GOOD_CNT, BAD_CNT, exp_good, exp_bad);
            bad++;
        end
        total++;
        if (gap_viol !== 0) begin $display("FAIL rand_popgap: got %0d back-to-back pops want 0", gap_viol); bad++; end
        ready_mode = 0;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_chk();
        test_garbage_empty();
        test_bad_len();
        test_stall_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Downstream consumer of the UART interface receive FIFO. Pops bytes with the READ_BUFFER handshake and hunts for frames of the form SOF, LEN, LEN payload bytes, CHK.
- Streams payload bytes out on a valid/ready port and reports one status pulse per frame.
- Keeps saturating good-frame and bad-frame counters for the microcontroller.

Parameters:
- SOF_BYTE, 8'h7E, start-of-frame marker.
- MAX_LEN, 64, largest legal LEN value (1..255).
- TIMEOUT_CYCLES, 100000, idle CLK cycles allowed between bytes inside a frame (≥2).

Ports:
- CLK  in  1  system clock, same domain as the UART FIFO.
- RST  in  1  synchronous, active-high reset.
- RXF_NOT_EMPTY  in  1  rx FIFO has data (UART INTERRUPT).
- RXF_DATA  in  8  head byte of the rx FIFO, first-word-fall-through (UART DATA_OUT).
- RXF_PARITY_ERR  in  1  parity flag of the head byte (UART PARITY).
- RXF_POP  out  1  one-cycle pop strobe (drives UART READ_BUFFER).
- OUT_DATA  out  8  payload byte.
- OUT_VALID  out  1  OUT_DATA valid.
- OUT_LAST  out  1  marks the final payload byte of a frame.
- OUT_READY  in  1  sink accepts the byte.
- FRAME_DONE  out  1  one-cycle pulse at frame end or abort.
- FRAME_STATUS  out  3  status code, valid with FRAME_DONE.
- GOOD_CNT  out  16  saturating count of frames with status 0.
- BAD_CNT  out  16  saturating count of frames with nonzero status.

Behaviour:
- Reset: while RST is high at a CLK edge, all outputs and counters go to 0 and the FSM goes to HUNT. Reset mid-frame discards the frame; no FRAME_DONE is issued.
- Pop rule:
  - Pop is allowed only when RXF_NOT_EMPTY=1, the pop-gap flag is clear, and the FSM can consume the byte.
  - RXF_DATA and RXF_PARITY_ERR are sampled in the same cycle RXF_POP=1.
  - After every pop, one gap cycle is forced so the FIFO flag can update. Maximum rate is 1 pop per 2 cycles.
- FSM states: HUNT, LEN, PAYLOAD, CHK.
  - HUNT: pop every byte. On SOF_BYTE with no parity error, go to LEN. Any other byte is dropped silently (no status).
  - LEN: pop the byte and set remaining=LEN and chk=LEN.
    - Parity error: status 3, go to HUNT.
    - LEN > MAX_LEN: status 2, go to HUNT.
    - LEN=0: go to CHK.
    - Otherwise go to PAYLOAD.
  - PAYLOAD: pop only if the output register is empty, or is being accepted this cycle.
    - Each popped byte loads the output register with OUT_VALID=1, sets chk ^= byte, and decrements remaining.
    - OUT_LAST=1 when remaining==1 before the decrement.
    - After the last byte, go to CHK.
    - A parity error on a payload byte sets a sticky perr flag; the byte is still forwarded.
  - CHK: pop the byte and finish the frame.
    - Status priority: perr or parity error on CHK gives 3; else byte != chk gives 1; else 0.
    - Pulse FRAME_DONE and go to HUNT.
- Output register: holds OUT_DATA, OUT_VALID and OUT_LAST stable until OUT_VALID & OUT_READY. It can drain after the FSM has left PAYLOAD.
- Timeout:
  - The counter runs in LEN, PAYLOAD and CHK. It clears on every pop and holds while OUT_VALID & ~OUT_READY.
  - On reaching TIMEOUT_CYCLES: status 4, FRAME_DONE, go to HUNT.
  - The counter is cleared in HUNT.
- FRAME_DONE is a single-cycle pulse. FRAME_STATUS holds its last value until the next pulse.
- Status codes: 0 OK, 1 checksum, 2 length, 3 parity, 4 timeout.
- Counters: on FRAME_DONE, GOOD_CNT or BAD_CNT increments by 1 and saturates at 16'hFFFF.
- Simultaneous events: a timeout in the same cycle as a pop is ignored; the pop wins.

Decomposition:
- Shared package uart_pkg:
  - enum deframe_state_t {HUNT, LEN, PAYLOAD, CHK}.
  - 3-bit frame_status_t with constants ST_OK, ST_CHK, ST_LEN, ST_PAR, ST_TMO.
  - Default SOF constant.
- One sub-module, sat_counter16 (increment enable, synchronous reset, saturating), instantiated twice.

Test Plan:
- Bytes 7E 03 11 22 33 (03^11^22^33=03) with OUT_READY=1 -> OUT_DATA 11, 22, 33; OUT_LAST only on 33; FRAME_DONE with status 0; GOOD_CNT=1.
- Same frame with CHK=FF -> payload still streamed; status 1; BAD_CNT=1.
- Bytes 55 AA 7E 00 00 -> leading garbage dropped with no FRAME_DONE; empty frame gives status 0 and OUT_VALID never asserted.
- Bytes 7E 41 (MAX_LEN=64) -> status 2; the following bytes 7E 01 5A 5B are parsed as a clean frame with status 0.
- OUT_READY held low for 1000 cycles mid-payload with TIMEOUT_CYCLES=50 -> no timeout, OUT_DATA stable, no pops. Then stop the FIFO after 7E 02 01 -> status 4 exactly 50 cycles after the last pop.
- RST pulsed high mid-PAYLOAD -> all outputs 0, no FRAME_DONE; the next full frame passes with status 0. Parity flag set on a payload byte -> status 3.
